scan_chain_sequencer: RTL and testbench

- Sequences a chain of mux-select scan flops: each flop has D0 (functional data), D1 (scan data), SD (select), SP (clock enable) and CK.
- Drives the chain's shared SD/SP controls and the serial scan input, and samples the serial scan output.
- Host side issues capture/shift commands through a valid/ready handshake and receives the unloaded word via a response handshake.
- Used for register readback/preload and built-in test of flop arrays in the fabric.

---
 rtl/scan_chain_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_scan_chain_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_chain_sequencer.sv
// Scan chain sequencer for a chain of mux-select scan flops.
// Drives the shared SD/SP controls and the serial scan input, samples the
// serial scan output, and exchanges capture/shift commands and unloaded
// words with the host over valid/ready handshakes.
// Optional build macro: SCAN_PAUSE_EN adds a 'pause' input that stalls
// shifting without losing or duplicating bits.
//
// state | meaning
// IDLE  | waiting for a command, chain clock disabled
// CAP   | one cycle with sd=0, sp=1: chain loads functional D0 data
// SHF   | sd=1, sp=1: one bit in on chain_si, one bit out from chain_so per cycle
// DONE  | response held on resp_rx until the host accepts it
module scan_chain_sequencer #(
    parameter int CHAIN_LEN = 32,
    parameter int CNT_W     = 7
) (
    input  logic                 CK,
    input  logic                 RSTN,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [CNT_W-1:0]     cmd_len,
    input  logic [CHAIN_LEN-1:0] cmd_tx,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [CHAIN_LEN-1:0] resp_rx,
    output logic                 busy,
`ifdef SCAN_PAUSE_EN
    input  logic                 pause,
`endif
    output logic                 chain_sd,
    output logic                 chain_sp,
    output logic                 chain_si,
    input  logic                 chain_so
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CAP  = 2'd1,
        S_SHF  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] OP_CAP    = 2'b00;
    localparam logic [1:0] OP_SHF    = 2'b01;
    localparam logic [1:0] OP_CAPSHF = 2'b10;

    localparam logic [CNT_W-1:0]     LEN_MAX = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0]     CNT_ONE = CNT_W'(1);
    localparam logic [CHAIN_LEN-1:0] BIT_ONE = CHAIN_LEN'(1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           op_q, op_d;
    logic [CNT_W-1:0]     len_q, len_d;
    logic [CHAIN_LEN-1:0] tx_q, tx_d;
    logic [CHAIN_LEN-1:0] rx_q, rx_d;
    logic                 sd_q, sd_d;
    logic                 sp_q, sp_d;
    logic                 si_q, si_d;
    logic                 rv_q, rv_d;
    logic [CNT_W-1:0]     len_eff;
    logic [CHAIN_LEN-1:0] so_vec;
    logic                 pause_i;

`ifdef SCAN_PAUSE_EN
    assign pause_i = pause;
`else
    assign pause_i = 1'b0;
`endif

    // Out-of-range and zero lengths both mean a full-chain shift.
    assign len_eff = (cmd_len == '0 || cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
    assign so_vec  = {{(CHAIN_LEN-1){1'b0}}, chain_so};

    assign cmd_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign resp_valid = rv_q;
    assign resp_rx    = rx_q;
    assign chain_sd   = sd_q;
    assign chain_sp   = sp_q;
    assign chain_si   = si_q;

    // Next-state and next-output decode; chain controls are registered so
    // they are computed for the state being entered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        len_d   = len_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        sd_d    = 1'b0;
        sp_d    = 1'b0;
        si_d    = 1'b0;
        rv_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d  = cmd_op;
                    len_d = len_eff;
                    tx_d  = cmd_tx;
                    cnt_d = '0;
                    rx_d  = '0;
                    case (cmd_op)
                        OP_CAP, OP_CAPSHF: begin
                            state_d = S_CAP;
                            sp_d    = 1'b1;
                        end
                        OP_SHF: begin
                            state_d = S_SHF;
                            sd_d    = 1'b1;
                            sp_d    = 1'b1;
                            si_d    = cmd_tx[0];
                        end
                        default: begin
                            state_d = S_DONE;
                            rv_d    = 1'b1;
                        end
                    endcase
                end
            end
            S_CAP: begin
                if (op_q == OP_CAPSHF) begin
                    state_d = S_SHF;
                    sd_d    = 1'b1;
                    sp_d    = 1'b1;
                    si_d    = tx_q[0];
                end else begin
                    state_d = S_DONE;
                    rv_d    = 1'b1;
                end
            end
            S_SHF: begin
                // A cycle with sp low is a paused cycle: nothing moves and
                // si is held so the resumed edge shifts in the same bit.
                sd_d = 1'b1;
                si_d = si_q;
                sp_d = ~pause_i;
                if (sp_q) begin
                    rx_d  = rx_q | (so_vec << cnt_q);
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_d == len_q) begin
                        state_d = S_DONE;
                        sd_d    = 1'b0;
                        sp_d    = 1'b0;
                        si_d    = 1'b0;
                        rv_d    = 1'b1;
                    end else begin
                        si_d = |(tx_q & (BIT_ONE << cnt_d));
                    end
                end
            end
            S_DONE: begin
                rv_d = 1'b1;
                if (resp_ready) begin
                    state_d = S_IDLE;
                    rv_d    = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counter, latched command and registered chain controls.
    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            len_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            sd_q    <= 1'b0;
            sp_q    <= 1'b0;
            si_q    <= 1'b0;
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            len_q   <= len_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            sd_q    <= sd_d;
            sp_q    <= sp_d;
            si_q    <= si_d;
            rv_q    <= rv_d;
        end
    end

endmodule

// File: tb/tb_scan_chain_sequencer.sv
// Directed bench for scan_chain_sequencer with an 8-flop behavioural chain.
// chain[0] is the last flop (drives chain_so); chain_si enters at chain[7].
// Latency is counted in rising edges starting with the accept edge.
module tb_scan_chain_sequencer;
    localparam int CL = 8;
    localparam int CW = 7;

    logic          CK = 1'b0;
    logic          RSTN = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'b11;
    logic [CW-1:0] cmd_len = '0;
    logic [CL-1:0] cmd_tx = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [CL-1:0] resp_rx;
    logic          busy;
    logic          pause_drv = 1'b0;
    logic          chain_sd, chain_sp, chain_si, chain_so;

    logic [CL-1:0] chain = '0;
    logic [CL-1:0] d0 = '0;
    logic [CL-1:0] load_val = '0;
    logic          load_en = 1'b0;

    int tests = 0;
    int fails = 0;

    scan_chain_sequencer #(.CHAIN_LEN(CL), .CNT_W(CW)) dut (
        .CK(CK),
        .RSTN(RSTN),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_len(cmd_len),
        .cmd_tx(cmd_tx),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rx(resp_rx),
        .busy(busy),
`ifdef SCAN_PAUSE_EN
        .pause(pause_drv),
`endif
        .chain_sd(chain_sd),
        .chain_sp(chain_sp),
        .chain_si(chain_si),
        .chain_so(chain_so)
    );

    always #5 CK = ~CK;

    assign chain_so = chain[0];

    // Behavioural mux-select scan chain with a bench-side preload path.
    always @(posedge CK) begin
        if (load_en)
            chain <= load_val;
        else if (chain_sp)
            chain <= chain_sd ? {chain_si, chain[CL-1:1]} : d0;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [CL-1:0] val);
        @(negedge CK);
        load_val = val;
        load_en  = 1'b1;
        @(posedge CK);
        #1;
        load_en  = 1'b0;
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [CW-1:0] len,
                           input logic [CL-1:0] tx, input int pause_at,
                           output int lat, output int sp_cnt, output int cap_cnt);
        int left;
        bit trig;
        @(negedge CK);
        check("ready_before_accept", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        cmd_tx    = tx;
        @(posedge CK);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b11;
        lat = 1; sp_cnt = 0; cap_cnt = 0; left = 0; trig = 0;
        while (lat < 200) begin
            @(negedge CK);
            if (resp_valid) break;
            if (chain_sp && chain_sd) sp_cnt++;
            if (chain_sp && !chain_sd) cap_cnt++;
            if (!trig && pause_at > 0 && chain_sp && sp_cnt == pause_at) begin
                pause_drv = 1'b1;
                left = 3;
                trig = 1;
            end else if (left > 0) begin
                left--;
            end else begin
                pause_drv = 1'b0;
            end
            @(posedge CK);
            lat++;
        end
        pause_drv = 1'b0;
        check("resp_valid_within_budget", resp_valid, 1);
    endtask

    task automatic ack();
        @(negedge CK);
        cmd_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge CK);
        #1;
        resp_ready = 1'b0;
        check("ack_cmd_ready", cmd_ready, 1);
        check("ack_resp_valid_low", resp_valid, 0);
    endtask

    initial begin
        int lat, spc, capc;
        logic [CL-1:0] snap;
        bit seen;

        // Reset state
        #12;
        check("rst_sd", chain_sd, 0);
        check("rst_sp", chain_sp, 0);
        check("rst_si", chain_si, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_rx", resp_rx, 0);
        check("rst_busy", busy, 0);
        @(negedge CK);
        RSTN = 1'b1;
        #1;
        check("rst_cmd_ready", cmd_ready, 1);

        // Full SHIFT: unload 0xA5, load 0x3C
        preload(8'hA5);
        run_cmd(2'b01, 7'd0, 8'h3C, 0, lat, spc, capc);
        check("shf_latency", lat, 9);
        check("shf_rx", resp_rx, 8'hA5);
        check("shf_chain", chain, 8'h3C);
        check("shf_sp_cycles", spc, 8);
        check("shf_cap_cycles", capc, 0);
        check("done_busy", busy, 1);
        check("done_cmd_ready", cmd_ready, 0);

        // Backpressure in DONE with a competing CAPTURE command
        for (int i = 0; i < 5; i++) begin
            @(negedge CK);
            cmd_valid = 1'b1;
            cmd_op    = 2'b00;
            check("bp_cmd_ready", cmd_ready, 0);
            check("bp_sp", chain_sp, 0);
            check("bp_resp_valid", resp_valid, 1);
            check("bp_rx_stable", resp_rx, 8'hA5);
        end
        ack();
        cmd_op = 2'b11;
        @(negedge CK);
        check("bp_chain_untouched", chain, 8'h3C);
        check("bp_no_second_resp", resp_valid, 0);

        // CAPTURE_SHIFT: capture D0=0x5A over a chain of 0xFF
        d0 = 8'h5A;
        preload(8'hFF);
        run_cmd(2'b10, 7'd0, 8'h00, 0, lat, spc, capc);
        check("cs_latency", lat, 10);
        check("cs_cap_cycles", capc, 1);
        check("cs_sp_cycles", spc, 8);
        check("cs_rx", resp_rx, 8'h5A);
        check("cs_chain", chain, 8'h00);
        ack();

        // Partial length 3
        preload(8'b1111_0110);
        run_cmd(2'b01, 7'd3, 8'h05, 0, lat, spc, capc);
        check("len3_latency", lat, 4);
        check("len3_sp_cycles", spc, 3);
        check("len3_rx", resp_rx, 8'b0000_0110);
        check("len3_chain", chain, 8'hBE);
        ack();

        // Clamped length 20 behaves as 8
        preload(8'hC3);
        run_cmd(2'b01, 7'd20, 8'h81, 0, lat, spc, capc);
        check("len20_latency", lat, 9);
        check("len20_sp_cycles", spc, 8);
        check("len20_rx", resp_rx, 8'hC3);
        check("len20_chain", chain, 8'h81);
        ack();

        // Pure CAPTURE returns zero
        d0 = 8'h3E;
        preload(8'h00);
        run_cmd(2'b00, 7'd0, 8'hFF, 0, lat, spc, capc);
        check("cap_latency", lat, 2);
        check("cap_cap_cycles", capc, 1);
        check("cap_sp_cycles", spc, 0);
        check("cap_rx", resp_rx, 8'h00);
        check("cap_chain", chain, 8'h3E);
        ack();

        // NOP
        run_cmd(2'b11, 7'd5, 8'hFF, 0, lat, spc, capc);
        check("nop_latency", lat, 1);
        check("nop_rx", resp_rx, 8'h00);
        check("nop_sp_cycles", spc + capc, 0);
        check("nop_chain", chain, 8'h3E);
        ack();

        // Reset in the third shift cycle aborts without a response
        preload(8'h0F);
        @(negedge CK);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_len   = 7'd0;
        cmd_tx    = 8'hFF;
        @(posedge CK);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b11;
        repeat (3) @(negedge CK);
        check("abort_in_shift", chain_sp, 1);
        check("abort_rx_before", resp_rx, 8'h03);
        #2;
        RSTN = 1'b0;
        #1;
        check("abort_sd", chain_sd, 0);
        check("abort_sp", chain_sp, 0);
        check("abort_si", chain_si, 0);
        check("abort_resp_valid", resp_valid, 0);
        check("abort_rx", resp_rx, 0);
        check("abort_busy", busy, 0);
        snap = chain;
        @(negedge CK);
        RSTN = 1'b1;
        #1;
        check("abort_cmd_ready", cmd_ready, 1);
        seen = 0;
        repeat (20) begin
            @(negedge CK);
            if (resp_valid) seen = 1;
        end
        check("abort_no_resp", seen, 0);
        check("abort_chain_held", chain, snap);

`ifdef SCAN_PAUSE_EN
        // Four paused cycles in the middle of the 0xA5/0x3C shift
        preload(8'hA5);
        run_cmd(2'b01, 7'd0, 8'h3C, 5, lat, spc, capc);
        check("pause_latency", lat, 13);
        check("pause_sp_cycles", spc, 8);
        check("pause_rx", resp_rx, 8'hA5);
        check("pause_chain", chain, 8'h3C);
        ack();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
